// File: rtl/posit_pkg.sv
// Shared posit<32,3> definitions used by both the posit encoder and decoder.
package posit_pkg;

  localparam int NBITS     = 32;
  localparam int ES        = 3;
  localparam int FRAC_W    = 28;
  localparam int K_W       = 11;
  localparam int MAX_SCALE = 240;

  localparam logic [NBITS-1:0] POSIT_NAR    = 32'h8000_0000;
  localparam logic [NBITS-1:0] POSIT_MAXPOS = 32'h7FFF_FFFF;
  localparam logic [NBITS-1:0] POSIT_MINPOS = 32'h0000_0001;

  typedef struct packed {
    logic                  sign;
    logic signed [K_W-1:0] k;
    logic [ES-1:0]         e;
    logic [FRAC_W-1:0]     frac;
    logic                  sticky;
    logic                  zero;
    logic                  nar;
    logic                  sat_max;
    logic                  sat_min;
  } s1_payload_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             nar;
    logic             sat_max;
    logic             sat_min;
    logic [NBITS-2:0] field;
    logic             guard;
    logic             sticky;
  } s2_payload_t;

endpackage

// File: rtl/posit_regime_gen.sv
// Builds the regime-prefixed 31-bit posit magnitude field plus guard/sticky
// from regime value k, exponent e and fraction.
module posit_regime_gen
  import posit_pkg::*;
(
  input  logic signed [K_W-1:0] k,
  input  logic [ES-1:0]         e,
  input  logic [FRAC_W-1:0]     frac,
  output logic [NBITS-2:0]      field,
  output logic                  guard,
  output logic                  sticky
);

  logic [K_W-1:0] sh;
  logic [63:0]    seed;
  logic [63:0]    shifted;

  // Seed "10" (k>=0) or "01" (k<0) ahead of e/frac; the arithmetic shift then
  // replicates the leading regime digit so the run length comes out right.
  always_comb begin
    sh      = k[K_W-1] ? ~k : k;
    seed    = {(k[K_W-1] ? 2'b01 : 2'b10), e, frac, 31'b0};
    shifted = $signed(seed) >>> sh;
    field   = shifted[63:33];
    guard   = shifted[32];
    sticky  = |shifted[31:0];
  end

endmodule

// File: rtl/posit_enc.sv
// Three-stage posit<32,3> encoder with valid/ready flow control.
// POSIT_ENC_ROUND_EN enables round-to-nearest-even; otherwise the magnitude is truncated.
module posit_enc #(
  parameter int NBITS   = 32,
  parameter int ES      = 3,
  parameter int SCALE_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic               in_zero,
  input  logic               in_nar,
  input  logic [SCALE_W-1:0] in_scale,
  input  logic [27:0]        in_frac,
  input  logic               in_sticky,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NBITS-1:0]   out_posit
);
  import posit_pkg::*;

`ifdef POSIT_ENC_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic signed [SCALE_W:0] SCALE_HI = (SCALE_W+1)'(MAX_SCALE);
  localparam logic signed [SCALE_W:0] SCALE_LO = (SCALE_W+1)'(-MAX_SCALE);

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_payload_t      s1_q, s1_d;
  s2_payload_t      s2_q, s2_d;
  logic [NBITS-1:0] posit_q, posit_d;
  logic             load1, load2, load3;
  logic signed [SCALE_W:0] scale_ext;
  logic [NBITS-2:0] rg_field;
  logic             rg_guard, rg_sticky;
  logic             round_inc;
  logic [NBITS-1:0] mag;

  // A stage loads when empty or when its successor advances, so bubbles collapse.
  always_comb begin
    load3 = !v3_q || out_ready;
    load2 = !v2_q || load3;
    load1 = !v1_q || load2;
  end

  assign in_ready  = load1;
  assign out_valid = v3_q;
  assign out_posit = posit_q;

  always_comb begin
    scale_ext = {in_scale[SCALE_W-1], in_scale};
    v1_d      = v1_q;
    s1_d      = s1_q;
    if (load1) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_d.sign    = in_sign;
        s1_d.k       = K_W'(scale_ext >>> ES);
        s1_d.e       = in_scale[ES-1:0];
        s1_d.frac    = in_frac;
        s1_d.sticky  = in_sticky;
        s1_d.zero    = in_zero;
        s1_d.nar     = in_nar;
        s1_d.sat_max = scale_ext >= SCALE_HI;
        s1_d.sat_min = scale_ext < SCALE_LO;
      end
    end
  end

  posit_regime_gen u_regime (
    .k      (s1_q.k),
    .e      (s1_q.e),
    .frac   (s1_q.frac),
    .field  (rg_field),
    .guard  (rg_guard),
    .sticky (rg_sticky)
  );

  always_comb begin
    v2_d = v2_q;
    s2_d = s2_q;
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d.sign    = s1_q.sign;
        s2_d.zero    = s1_q.zero;
        s2_d.nar     = s1_q.nar;
        s2_d.sat_max = s1_q.sat_max;
        s2_d.sat_min = s1_q.sat_min;
        s2_d.field   = rg_field;
        s2_d.guard   = rg_guard;
        s2_d.sticky  = rg_sticky | s1_q.sticky;
      end
    end
  end

  // Rounding never produces zero or NaR: clamp to minpos / maxpos instead.
  always_comb begin
    round_inc = ROUND_EN & s2_q.guard & (s2_q.field[0] | s2_q.sticky);
    mag       = {1'b0, s2_q.field} + {{(NBITS-1){1'b0}}, round_inc};
    if (mag[NBITS-1]) mag = POSIT_MAXPOS;
    else if (mag == '0) mag = POSIT_MINPOS;
    v3_d    = v3_q;
    posit_d = posit_q;
    if (load3) begin
      v3_d = v2_q;
      if (v2_q) begin
        if (s2_q.nar) begin
          posit_d = POSIT_NAR;
        end else if (s2_q.zero) begin
          posit_d = '0;
        end else begin
          if (s2_q.sat_max)      posit_d = POSIT_MAXPOS;
          else if (s2_q.sat_min) posit_d = POSIT_MINPOS;
          else                   posit_d = mag;
          if (s2_q.sign) posit_d = -posit_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      posit_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      posit_q <= posit_d;
    end
  end

endmodule

// File: tb/tb_posit_enc.sv
// Self-checking bench for posit_enc against a bit-list reference model of posit<32,3>.
`timescale 1ns/1ps
module tb_posit_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic        in_zero = 1'b0;
  logic        in_nar = 1'b0;
  logic [9:0]  in_scale = '0;
  logic [27:0] in_frac = '0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_posit;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rand_ready_en = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          acc_cyc[$];
  int          out_cyc[$];

  typedef struct {
    bit          s, z, n;
    int          scale;
    logic [27:0] f;
    bit          st;
    logic [31:0] exp;
    string       name;
  } dvec_t;

  posit_enc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  // Reference: write the posit as a list of bits (regime, exponent, fraction),
  // keep the first 31, round on the rest, then saturate and negate.
  function automatic logic [31:0] model(bit s, bit z, bit n, int scale, logic [27:0] f, bit st);
    bit     bits[$];
    int     k, e;
    longint mag;
    bit     guard, sticky;
    if (n) return 32'h8000_0000;
    if (z) return 32'h0000_0000;
    if (scale >= 240) mag = 64'h7FFF_FFFF;
    else if (scale < -240) mag = 1;
    else begin
      k = (scale >= 0) ? scale / 8 : -((-scale + 7) / 8);
      e = scale - 8 * k;
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) bits.push_back(((e >> i) & 1) != 0);
      for (int i = 27; i >= 0; i--) bits.push_back(f[i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = mag * 2 + ((i < bits.size() && bits[i]) ? 1 : 0);
      guard  = (bits.size() > 31) ? bits[31] : 1'b0;
      sticky = st;
      for (int i = 32; i < bits.size(); i++) sticky = sticky | bits[i];
`ifdef POSIT_ENC_ROUND_EN
      if (guard && ((mag % 2 == 1) || sticky)) mag = mag + 1;
`else
      if (guard && sticky) mag = mag + 0;
`endif
      if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
      if (mag == 0) mag = 1;
    end
    if (s) mag = 64'h1_0000_0000 - mag;
    return mag[31:0];
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sign, in_zero, in_nar, int'($signed(in_scale)), in_frac, in_sticky));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        obs_q.push_back(out_posit);
        out_cyc.push_back(cyc);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready_en) out_ready = ($urandom_range(0, 1) == 1);
  end

  function automatic void clear_sb();
    exp_q.delete();
    obs_q.delete();
    acc_cyc.delete();
    out_cyc.delete();
  endfunction

  task automatic drive_word(input bit s, input bit z, input bit n, input int scale,
                            input logic [27:0] f, input bit st);
    in_sign   = s;
    in_zero   = z;
    in_nar    = n;
    in_scale  = 10'(scale);
    in_frac   = f;
    in_sticky = st;
  endtask

  task automatic send(input bit s, input bit z, input bit n, input int scale,
                      input logic [27:0] f, input bit st);
    bit got = 1'b0;
    int budget = 0;
    drive_word(s, z, n, scale, f, st);
    in_valid = 1'b1;
    while (!got && budget < 60) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_timeout: in_ready never rose within %0d cycles", budget);
    end
  endtask

  task automatic wait_outputs(input int n);
    int budget = 0;
    while (obs_q.size() < n && budget < 300) begin
      @(posedge clk);
      #1;
      budget++;
    end
  endtask

  task automatic send_random(input int lo, input int hi);
    send(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
         int'($urandom_range(0, hi - lo)) + lo, 28'($urandom()), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (out_posit !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_posit: got %08h want 00000000", out_posit);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    dvec_t dv[$];
    logic [31:0] rnd3, rnd2s;
`ifdef POSIT_ENC_ROUND_EN
    rnd3 = 32'h4000_0001;
    rnd2s = 32'h4000_0001;
`else
    rnd3 = 32'h4000_0000;
    rnd2s = 32'h4000_0000;
`endif
    dv.push_back('{0, 0, 0, 0,    28'h0, 0, 32'h4000_0000, "scale0"});
    dv.push_back('{1, 0, 0, 0,    28'h0, 0, 32'hC000_0000, "scale0_neg"});
    dv.push_back('{0, 0, 0, 1,    28'h0, 0, 32'h4400_0000, "scale1"});
    dv.push_back('{0, 0, 0, 8,    28'h0, 0, 32'h6000_0000, "scale8"});
    dv.push_back('{0, 0, 0, -8,   28'h0, 0, 32'h2000_0000, "scale_m8"});
    dv.push_back('{1, 1, 1, 300,  28'h5, 1, 32'h8000_0000, "nar"});
    dv.push_back('{1, 1, 0, 17,   28'h7, 0, 32'h0000_0000, "zero_neg"});
    dv.push_back('{0, 0, 0, 300,  28'h0, 0, 32'h7FFF_FFFF, "sat_max"});
    dv.push_back('{0, 0, 0, -300, 28'h0, 0, 32'h0000_0001, "sat_min"});
    dv.push_back('{1, 0, 0, -300, 28'h0, 0, 32'hFFFF_FFFF, "sat_min_neg"});
    dv.push_back('{0, 0, 0, 0,    28'h2, 0, 32'h4000_0000, "rne_tie_even"});
    dv.push_back('{0, 0, 0, 0,    28'h3, 0, rnd3,          "rne_up"});
    dv.push_back('{0, 0, 0, 0,    28'h2, 1, rnd2s,         "rne_sticky"});
    clear_sb();
    out_ready = 1'b1;
    foreach (dv[i]) send(dv[i].s, dv[i].z, dv[i].n, dv[i].scale, dv[i].f, dv[i].st);
    wait_outputs(dv.size());
    vectors++;
    if (obs_q.size() != dv.size()) begin
      miscompares++;
      $display("[TB] FAIL directed_count: got %0d want %0d", obs_q.size(), dv.size());
    end
    for (int i = 0; i < dv.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== dv[i].exp) begin
        miscompares++;
        $display("[TB] FAIL %s: got %08h want %08h", dv[i].name, obs_q[i], dv[i].exp);
      end
    end
  endtask

  task automatic test_random();
    clear_sb();
    rand_ready_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_random(-300, 300);
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_outputs(40);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: got %08h want %08h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_random(-60, 60);
    wait_outputs(16);
    vectors++;
    if (obs_q.size() != 16 || acc_cyc.size() != 16) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d outputs %0d accepts want 16", obs_q.size(), acc_cyc.size());
    end else begin
      vectors++;
      if (out_cyc[0] - acc_cyc[0] != 3) begin
        miscompares++;
        $display("[TB] FAIL b2b_latency: got %0d want 3", out_cyc[0] - acc_cyc[0]);
      end
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("[TB] FAIL b2b[%0d]: got %08h want %08h", i, obs_q[i], exp_q[i]);
        end
        if (i > 0) begin
          vectors++;
          if (out_cyc[i] != out_cyc[i-1] + 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_rate[%0d]: got gap %0d want 1", i, out_cyc[i] - out_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    int          sc[6];
    logic [27:0] fr[6];
    int          idx = 0;
    logic [31:0] held;
    for (int i = 0; i < 6; i++) begin
      sc[i] = int'($urandom_range(0, 100)) - 50;
      fr[i] = 28'($urandom());
    end
    clear_sb();
    out_ready = 1'b0;
    drive_word(0, 0, 0, sc[0], fr[0], 0);
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
      if (idx < 6) drive_word(0, 0, 0, sc[idx], fr[idx], 0);
    end
    vectors++;
    if (idx != 3) begin
      miscompares++;
      $display("[TB] FAIL stall_accepts: got %0d want 3", idx);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_in_ready: got %b want 0", in_ready);
    end
    held = out_posit;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_posit !== held || held !== exp_q[0]) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: got %08h valid %b want %08h", c, out_posit, out_valid, exp_q[0]);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
      if (idx < 6) drive_word(0, 0, 0, sc[idx], fr[idx], 0);
    end
    in_valid = 1'b0;
    wait_outputs(6);
    vectors++;
    if (obs_q.size() != 6 || exp_q.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL stall_count: got %0d outputs %0d accepts want 6", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL stall[%0d]: got %08h want %08h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_midreset();
    clear_sb();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 0, 0, 8 * i + 3, 28'h123_4567, 0);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_posit !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_clear: got valid %b posit %08h want 0 00000000", out_valid, out_posit);
    end
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_sb();
    send(0, 0, 0, 0, 28'h0, 0);
    wait_outputs(1);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h4000_0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_word: got %0d words first %08h want 1 word 40000000",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hx);
    end else begin
      vectors++;
      if (out_cyc[0] - acc_cyc[0] != 3) begin
        miscompares++;
        $display("[TB] FAIL midreset_latency: got %0d want 3", out_cyc[0] - acc_cyc[0]);
      end
    end
  endtask

  initial begin
    $display("[TB] posit_enc bench start");
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
